// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and writeback select for the rv32i core.
// Formats load data, picks the writeback source and counts retired instructions.
module writeback_stage #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [4:0]        rd_i,
  input  logic              regwren_i,
  input  logic [1:0]        wbsel_i,
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [DWIDTH-1:0] alu_res_i,
  input  logic [DWIDTH-1:0] mem_rdata_i,
  input  logic [AWIDTH-1:0] pc_i,
  output logic [4:0]        rd_o,
  output logic [DWIDTH-1:0] datawb_o,
  output logic              regwren_o,
  output logic              valid_o,
  output logic [63:0]       retired_count_o
);

  typedef struct packed {
    logic              valid;
    logic [4:0]        rd;
    logic              regwren;
    logic [1:0]        wbsel;
    logic [2:0]        funct3;
    logic [1:0]        addr_lo;
    logic [DWIDTH-1:0] alu_res;
    logic [DWIDTH-1:0] mem_rdata;
    logic [AWIDTH-1:0] pc;
  } wb_t;

  wb_t         wb_q, wb_d;
  logic [63:0] cnt_q, cnt_d;

  always_comb begin
    wb_d = wb_q;
    if (flush_i) begin
      wb_d = '0;
    end else if (!stall_i) begin
      wb_d.valid     = valid_i;
      wb_d.rd        = rd_i;
      wb_d.regwren   = regwren_i;
      wb_d.wbsel     = wbsel_i;
      wb_d.funct3    = funct3_i;
      wb_d.addr_lo   = addr_lo_i;
      wb_d.alu_res   = alu_res_i;
      wb_d.mem_rdata = mem_rdata_i;
      wb_d.pc        = pc_i;
    end
    // The instruction leaves WB whenever it is not stalled, even under flush.
    cnt_d = cnt_q + {63'd0, wb_q.valid & ~stall_i};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DWIDTH-1:0] ld_fmt;

  always_comb begin
    ld_byte = '0;
    case (wb_q.addr_lo)
      2'd0: ld_byte = wb_q.mem_rdata[7:0];
      2'd1: ld_byte = wb_q.mem_rdata[15:8];
      2'd2: ld_byte = wb_q.mem_rdata[23:16];
      2'd3: ld_byte = wb_q.mem_rdata[31:24];
      default: ld_byte = '0;
    endcase
    ld_half = wb_q.addr_lo[1] ? wb_q.mem_rdata[31:16] : wb_q.mem_rdata[15:0];
    ld_fmt  = wb_q.mem_rdata;
    case (wb_q.funct3)
      3'b000: ld_fmt = {{(DWIDTH-8){ld_byte[7]}}, ld_byte};
      3'b001: ld_fmt = {{(DWIDTH-16){ld_half[15]}}, ld_half};
      3'b100: ld_fmt = {{(DWIDTH-8){1'b0}}, ld_byte};
      3'b101: ld_fmt = {{(DWIDTH-16){1'b0}}, ld_half};
      default: ld_fmt = wb_q.mem_rdata;
    endcase
  end

  logic [AWIDTH-1:0] pc_plus4;
  assign pc_plus4 = wb_q.pc + AWIDTH'(4);

  always_comb begin
    datawb_o = '0;
    case (wb_q.wbsel)
      2'b00:   datawb_o = wb_q.alu_res;
      2'b01:   datawb_o = ld_fmt;
      2'b10:   datawb_o = DWIDTH'(pc_plus4);
      default: datawb_o = '0;
    endcase
  end

  assign rd_o            = wb_q.rd;
  assign regwren_o       = wb_q.valid & wb_q.regwren & (wb_q.rd != 5'd0);
  assign valid_o         = wb_q.valid;
  assign retired_count_o = cnt_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: expected writebacks are queued on
// drive and compared one cycle later; retire count tracked by a small model.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, stall_i, flush_i, regwren_i;
  logic [4:0]  rd_i;
  logic [1:0]  wbsel_i, addr_lo_i;
  logic [2:0]  funct3_i;
  logic [31:0] alu_res_i, mem_rdata_i, pc_i;
  logic [4:0]  rd_o;
  logic [31:0] datawb_o;
  logic        regwren_o, valid_o;
  logic [63:0] retired_count_o;

  always #5 clk = ~clk;

  writeback_stage #(.DWIDTH(32), .AWIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
    .rd_i(rd_i), .regwren_i(regwren_i), .wbsel_i(wbsel_i),
    .funct3_i(funct3_i), .addr_lo_i(addr_lo_i),
    .alu_res_i(alu_res_i), .mem_rdata_i(mem_rdata_i), .pc_i(pc_i),
    .rd_o(rd_o), .datawb_o(datawb_o), .regwren_o(regwren_o),
    .valid_o(valid_o), .retired_count_o(retired_count_o)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        wren;
  } exp_t;

  exp_t        sb[$];
  exp_t        held;
  int          checks = 0;
  int          errors = 0;
  logic        m_valid = 1'b0;
  logic [63:0] exp_cnt = '0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // One clock: drive inputs, advance model, check outputs #1 after the edge.
  task automatic cyc(input string tag, input logic v, input logic st, input logic fl,
                     input logic [4:0] rd, input logic wren, input logic [1:0] wbsel,
                     input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] alu,
                     input logic [31:0] mem, input logic [31:0] pc, input logic [31:0] exp_data);
    exp_t e;
    logic loads;
    valid_i = v; stall_i = st; flush_i = fl; rd_i = rd; regwren_i = wren;
    wbsel_i = wbsel; funct3_i = f3; addr_lo_i = lo; alu_res_i = alu;
    mem_rdata_i = mem; pc_i = pc;
    loads = !fl && !st && v;
    if (loads) begin
      e.rd = rd; e.data = exp_data; e.wren = wren && (rd != 5'd0);
      sb.push_back(e);
    end
    if (m_valid && !st) exp_cnt++;
    m_valid = fl ? 1'b0 : (st ? m_valid : v);
    @(posedge clk); #1;
    if (loads) begin
      if (sb.size() == 0) begin
        chk({tag, "_sb_empty"}, 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        held = e;
        chk({tag, "_rd"},   64'(rd_o),      64'(e.rd));
        chk({tag, "_data"}, 64'(datawb_o),  64'(e.data));
        chk({tag, "_wren"}, 64'(regwren_o), 64'(e.wren));
      end
    end else if (st && !fl && m_valid) begin
      chk({tag, "_hold_rd"},   64'(rd_o),     64'(held.rd));
      chk({tag, "_hold_data"}, 64'(datawb_o), 64'(held.data));
    end else begin
      chk({tag, "_nowren"}, 64'(regwren_o), 64'd0);
    end
    chk({tag, "_valid"}, 64'(valid_o), 64'(m_valid));
    chk({tag, "_cnt"}, retired_count_o, exp_cnt);
  endtask

  task automatic rand_inputs();
    valid_i = 1'($urandom); stall_i = 1'($urandom); flush_i = 1'($urandom);
    rd_i = 5'($urandom); regwren_i = 1'($urandom); wbsel_i = 2'($urandom);
    funct3_i = 3'($urandom); addr_lo_i = 2'($urandom);
    alu_res_i = $urandom; mem_rdata_i = $urandom; pc_i = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rand_inputs();
      @(posedge clk); #1;
    end
    chk("rst_rd", 64'(rd_o), 64'd0);
    chk("rst_data", 64'(datawb_o), 64'd0);
    chk("rst_wren", 64'(regwren_o), 64'd0);
    chk("rst_valid", 64'(valid_o), 64'd0);
    chk("rst_cnt", retired_count_o, 64'd0);
    rst = 1'b0;
    m_valid = 1'b0;
    exp_cnt = '0;
    sb.delete();
  endtask

  localparam logic [31:0] MEMW = 32'h80FF_7F01;

  initial begin
    do_reset();

    cyc("alu",  1, 0, 0, 5'd5, 1, 2'b00, 3'b010, 2'd0, 32'h1234_5678, 32'h0, 32'h0, 32'h1234_5678);
    cyc("lb3",  1, 0, 0, 5'd6, 1, 2'b01, 3'b000, 2'd3, 32'h0, MEMW, 32'h0, 32'hFFFF_FF80);
    cyc("lbu1", 1, 0, 0, 5'd7, 1, 2'b01, 3'b100, 2'd1, 32'h0, MEMW, 32'h0, 32'h0000_007F);
    cyc("lh2",  1, 0, 0, 5'd8, 1, 2'b01, 3'b001, 2'd2, 32'h0, MEMW, 32'h0, 32'hFFFF_80FF);
    cyc("lhu0", 1, 0, 0, 5'd9, 1, 2'b01, 3'b101, 2'd0, 32'h0, MEMW, 32'h0, 32'h0000_7F01);
    cyc("lw",   1, 0, 0, 5'd10, 1, 2'b01, 3'b010, 2'd2, 32'h0, MEMW, 32'h0, MEMW);
    cyc("lb0",  1, 0, 0, 5'd11, 1, 2'b01, 3'b000, 2'd0, 32'h0, MEMW, 32'h0, 32'h0000_0001);
    cyc("lhu3", 1, 0, 0, 5'd12, 1, 2'b01, 3'b101, 2'd3, 32'h0, MEMW, 32'h0, 32'h0000_80FF);
    cyc("f3_6", 1, 0, 0, 5'd13, 1, 2'b01, 3'b110, 2'd1, 32'h0, MEMW, 32'h0, MEMW);
    cyc("jal",  1, 0, 0, 5'd1, 1, 2'b10, 3'b000, 2'd0, 32'h0, 32'h0, 32'h0100_0010, 32'h0100_0014);
    cyc("jalw", 1, 0, 0, 5'd1, 1, 2'b10, 3'b000, 2'd0, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0000_0000);
    cyc("rsv",  1, 0, 0, 5'd2, 1, 2'b11, 3'b000, 2'd0, 32'hDEAD_BEEF, MEMW, 32'h40, 32'h0);
    cyc("x0",   1, 0, 0, 5'd0, 1, 2'b00, 3'b000, 2'd0, 32'hCAFE_0000, 32'h0, 32'h0, 32'hCAFE_0000);
    cyc("nowr", 1, 0, 0, 5'd3, 0, 2'b00, 3'b000, 2'd0, 32'h0000_0055, 32'h0, 32'h0, 32'h0000_0055);
    cyc("bub",  0, 0, 0, 5'd4, 1, 2'b00, 3'b000, 2'd0, 32'h1111_1111, 32'h0, 32'h0, 32'h0);
    cyc("bub2", 0, 0, 0, 5'd4, 1, 2'b00, 3'b000, 2'd0, 32'h2222_2222, 32'h0, 32'h0, 32'h0);

    // Stall while inputs keep changing: outputs hold, count waits for release.
    cyc("pre",  1, 0, 0, 5'd7, 1, 2'b00, 3'b000, 2'd0, 32'h0000_00AA, 32'h0, 32'h0, 32'h0000_00AA);
    for (int i = 0; i < 3; i++)
      cyc("stl", 1, 1, 0, 5'(20 + i), 1, 2'b10, 3'b000, 2'd0, $urandom, $urandom, $urandom, 32'h0);
    cyc("rel",  0, 0, 0, 5'd9, 1, 2'b00, 3'b000, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);

    // Flush wins over stall.
    cyc("preF", 1, 0, 0, 5'd15, 1, 2'b00, 3'b000, 2'd0, 32'h0000_0BBB, 32'h0, 32'h0, 32'h0000_0BBB);
    cyc("fls",  1, 1, 1, 5'd16, 1, 2'b00, 3'b000, 2'd0, 32'h0000_0CCC, 32'h0, 32'h0, 32'h0);
    chk("fls_data", 64'(datawb_o), 64'd0);
    // Flush alone still counts the instruction leaving WB.
    cyc("preG", 1, 0, 0, 5'd17, 1, 2'b00, 3'b000, 2'd0, 32'h0000_0DDD, 32'h0, 32'h0, 32'h0000_0DDD);
    cyc("fl2",  1, 0, 1, 5'd18, 1, 2'b00, 3'b000, 2'd0, 32'h0000_0EEE, 32'h0, 32'h0, 32'h0);

    // Mid-operation reset, then traffic resumes from a zero count.
    cyc("preR", 1, 0, 0, 5'd19, 1, 2'b00, 3'b000, 2'd0, 32'h0000_0FFF, 32'h0, 32'h0, 32'h0000_0FFF);
    do_reset();
    cyc("post", 1, 0, 0, 5'd21, 1, 2'b00, 3'b000, 2'd0, 32'h0000_1234, 32'h0, 32'h0, 32'h0000_1234);
    cyc("post2", 0, 0, 0, 5'd0, 0, 2'b00, 3'b000, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
